// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared sizing constants for the unified instruction/data RAM
package ram_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 16;
  localparam int WORD_OFFSET = 2;
  localparam int MEM_DEPTH   = 2 ** (ADDR_WIDTH - WORD_OFFSET);
endpackage

// File: rtl/dual_port_ram_if.sv
// rtl/dual_port_ram_if.sv - fetch port and load/store port of the unified RAM
interface dual_port_ram_if #(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_read_data;
  logic                  wEn;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [DATA_WIDTH-1:0] d_write_data;
  logic [DATA_WIDTH-1:0] d_read_data;

  modport master (
    output i_address, wEn, d_address, d_write_data,
    input  i_read_data, d_read_data
  );

  modport slave (
    input  i_address, wEn, d_address, d_write_data,
    output i_read_data, d_read_data
  );
endinterface

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - word-organised RAM, combinational reads on both ports, synchronous data-port writes
module dual_port_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  dual_port_ram_if.slave  bus
);
  localparam int IDX_WIDTH = ADDR_WIDTH - WORD_OFFSET;
  localparam int DEPTH     = 2 ** IDX_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_WIDTH-1:0]  i_index;
  logic [IDX_WIDTH-1:0]  d_index;
  logic                  unused_byte_lanes;

  // Byte offset within a word is ignored: only whole-word accesses exist.
  assign i_index           = bus.i_address[ADDR_WIDTH-1:WORD_OFFSET];
  assign d_index           = bus.d_address[ADDR_WIDTH-1:WORD_OFFSET];
  assign unused_byte_lanes = ^{bus.i_address[WORD_OFFSET-1:0], bus.d_address[WORD_OFFSET-1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (bus.wEn) begin
      mem[d_index] <= bus.d_write_data;
    end
  end

  // No write-through: a same-cycle write becomes visible only after the edge.
  assign bus.i_read_data = mem[i_index];
  assign bus.d_read_data = mem[d_index];
endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - scoreboard bench for dual_port_ram
module tb_dual_port_ram;
  import ram_pkg::*;

  typedef struct {
    string                 name;
    logic                  chk_d;
    logic                  chk_i;
    logic [DATA_WIDTH-1:0] exp_d;
    logic [DATA_WIDTH-1:0] exp_i;
  } exp_t;

  logic clock;
  logic reset;
  logic sample_strobe;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  dual_port_ram_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  dual_port_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: pops one expectation per strobe and compares it to the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge sample_strobe);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=strobe required=queued_entry");
      end else begin
        e = sb_q.pop_front();
        if (e.chk_d) begin
          checks++;
          if (bus.d_read_data !== e.exp_d) begin
            failures++;
            $display("FAIL %s d_read_data actual=0x%08h required=0x%08h", e.name, bus.d_read_data, e.exp_d);
          end
        end
        if (e.chk_i) begin
          checks++;
          if (bus.i_read_data !== e.exp_i) begin
            failures++;
            $display("FAIL %s i_read_data actual=0x%08h required=0x%08h", e.name, bus.i_read_data, e.exp_i);
          end
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic cd, input logic [31:0] ed,
                            input logic ci, input logic [31:0] ei);
    exp_t e;
    e.name  = name;
    e.chk_d = cd;
    e.chk_i = ci;
    e.exp_d = ed;
    e.exp_i = ei;
    sb_q.push_back(e);
    sample_strobe = 1'b1;
    #1;
    sample_strobe = 1'b0;
    #1;
  endtask

  task automatic write_word(input string name, input logic [15:0] a, input logic [31:0] d,
                            input logic [31:0] exp_after);
    @(negedge clock);
    bus.wEn          = 1'b1;
    bus.d_address    = a;
    bus.d_write_data = d;
    @(posedge clock);
    #2;
    bus.wEn = 1'b0;
    expect_out(name, 1'b1, exp_after, 1'b0, 32'h0);
  endtask

  task automatic read_pair(input string name, input logic [15:0] da, input logic [31:0] ed,
                           input logic [15:0] ia, input logic [31:0] ei);
    @(negedge clock);
    bus.d_address = da;
    bus.i_address = ia;
    #2;
    expect_out(name, 1'b1, ed, 1'b1, ei);
  endtask

  initial begin
    int wait_cycles;
    checks           = 0;
    failures         = 0;
    sample_strobe    = 1'b0;
    reset            = 1'b0;
    bus.wEn          = 1'b0;
    bus.d_address    = '0;
    bus.i_address    = '0;
    bus.d_write_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    read_pair("rst_d0_i0", 16'd0, 32'h0, 16'd0, 32'h0);
    read_pair("rst_d4",    16'd4, 32'h0, 16'd0, 32'h0);
    read_pair("rst_d8",    16'd8, 32'h0, 16'd0, 32'h0);

    write_word("wr_0_at_0", 16'd0, 32'h0, 32'h0);
    write_word("wr_1_at_4", 16'd4, 32'h1, 32'h1);
    write_word("wr_2_at_8", 16'd8, 32'h2, 32'h2);

    write_word("wr_6_at_9", 16'd9, 32'h6, 32'h6);
    read_pair("alias_8_of_9", 16'd8, 32'h6, 16'd10, 32'h6);

    // Write enable low: data and address wiggle but memory holds.
    @(negedge clock);
    bus.wEn          = 1'b0;
    bus.d_address    = 16'd8;
    bus.d_write_data = 32'h4;
    for (int n = 0; n < 3; n++) begin
      @(posedge clock);
      #2;
      expect_out("wen0_hold_8", 1'b1, 32'h6, 1'b0, 32'h0);
    end
    read_pair("wen0_word4", 16'd4, 32'h1, 16'd0, 32'h0);

    read_pair("dual_d8_i4", 16'd8, 32'h6, 16'd4, 32'h1);

    // Same word on both ports, write to the last word: old before edge, new after.
    @(negedge clock);
    bus.d_address    = 16'hFFFF;
    bus.i_address    = 16'hFFFF;
    bus.d_write_data = 32'hA5A5A5A5;
    bus.wEn          = 1'b1;
    #2;
    expect_out("last_before_edge", 1'b1, 32'h0, 1'b1, 32'h0);
    @(posedge clock);
    #2;
    bus.wEn = 1'b0;
    expect_out("last_after_edge", 1'b1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5);
    read_pair("last_alias_fffc", 16'hFFFC, 32'hA5A5A5A5, 16'hFFFD, 32'hA5A5A5A5);
    read_pair("first_word_intact", 16'd0, 32'h0, 16'd4, 32'h1);

    // Asynchronous reset mid-cycle, then a write attempted while held in reset.
    @(negedge clock);
    bus.d_address = 16'hFFFF;
    bus.i_address = 16'd8;
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_reset_drop", 1'b1, 32'h0, 1'b1, 32'h0);
    bus.wEn          = 1'b1;
    bus.d_write_data = 32'h12345678;
    @(posedge clock);
    #2;
    expect_out("write_in_reset", 1'b1, 32'h0, 1'b1, 32'h0);
    bus.wEn = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    read_pair("post_reset_4_8", 16'd4, 32'h0, 16'd8, 32'h0);

    write_word("post_reset_wr", 16'd12, 32'hCAFEF00D, 32'hCAFEF00D);
    read_pair("post_reset_rd", 16'd0, 32'h0, 16'd14, 32'hCAFEF00D);

    wait_cycles = 0;
    while (sb_q.size() != 0 && wait_cycles < 100) begin
      @(posedge clock);
      wait_cycles++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
